// File: rtl/alu_logic_pkg.sv
// Shared definitions for the MIPS25 ALU bitwise logic unit.
package alu_logic_pkg;

  localparam int LOGIC_OP_W = 3;

  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NOR   = 3'd3,
    OP_NAND  = 3'd4,
    OP_ANDN  = 3'd5,
    OP_PASSA = 3'd6,
    OP_RSVD  = 3'd7
  } logic_op_t;

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline slot: a valid bit plus a payload register. The slot loads
// whenever it is allowed to take a new entry (it is empty or its occupant is
// leaving); the payload only changes when a real entry arrives, so an empty
// slot keeps showing the last value it carried.
module logic_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clkpos,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Slot state: clear on reset, take the upstream entry (or a bubble) on load, hold otherwise
  always_ff @(posedge clkpos or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (load_en) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end else begin
        data_r <= data_r;
      end
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: decodes the op at acceptance, then carries the
// result and its flags through PIPE_STAGES slots with bubble-collapsing
// valid/ready flow control.
module logic_unit_pipe
  import alu_logic_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clkpos,
  input  logic                  rst_n,
  input  logic                  vdd,
  input  logic                  vss,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOGIC_OP_W-1:0] op,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  zero,
  output logic                  parity,
  output logic                  op_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             parity;
    logic             op_err;
  } logic_stage_t;

  localparam int SW = $bits(logic_stage_t);

  function automatic logic calc_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Supply pins exist only for netlist compatibility.
  logic unused_supply_s;
  assign unused_supply_s = vdd ^ vss;

  logic [WIDTH-1:0]       result_s;
  logic                   err_s;
  logic_stage_t           stage_in_s;
  logic [PIPE_STAGES-1:0] valid_vec_s;
  logic [PIPE_STAGES-1:0] ready_vec_s;
  logic [SW-1:0]          data_vec_s [0:PIPE_STAGES-1];
  logic_stage_t           out_stage_s;

  // Operation decode; the reserved code yields zero and raises the error flag
  always_comb begin
    result_s = '0;
    err_s    = 1'b0;
    case (logic_op_t'(op))
      OP_AND:   result_s = a & b;
      OP_OR:    result_s = a | b;
      OP_XOR:   result_s = a ^ b;
      OP_NOR:   result_s = ~(a | b);
      OP_NAND:  result_s = ~(a & b);
      OP_ANDN:  result_s = a & ~b;
      OP_PASSA: result_s = a;
      OP_RSVD: begin
        result_s = '0;
        err_s    = 1'b1;
      end
      default: begin
        result_s = '0;
        err_s    = 1'b1;
      end
    endcase
  end

  // Bundle the result with its flags for capture into the first slot
  always_comb begin
    stage_in_s        = '0;
    stage_in_s.data   = result_s;
    stage_in_s.zero   = (result_s == '0);
    stage_in_s.parity = calc_parity(result_s);
    stage_in_s.op_err = err_s;
  end

  // Slot k may load when out_ready is high or any slot from k to the end is
  // empty; this is the unrolled form of "empty or downstream advancing" and
  // avoids a combinational chain through a single vector.
  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    assign ready_vec_s[k] = out_ready | ~(&valid_vec_s[PIPE_STAGES-1:k]);

    if (k == 0) begin : g_first
      logic_pipe_stage #(.W(SW)) u_stage (
        .clkpos   (clkpos),
        .rst_n    (rst_n),
        .load_en  (ready_vec_s[k]),
        .in_valid (in_valid),
        .in_data  (stage_in_s),
        .valid    (valid_vec_s[k]),
        .data     (data_vec_s[k])
      );
    end else begin : g_next
      logic_pipe_stage #(.W(SW)) u_stage (
        .clkpos   (clkpos),
        .rst_n    (rst_n),
        .load_en  (ready_vec_s[k]),
        .in_valid (valid_vec_s[k-1]),
        .in_data  (data_vec_s[k-1]),
        .valid    (valid_vec_s[k]),
        .data     (data_vec_s[k])
      );
    end
  end

  assign in_ready    = ready_vec_s[0];
  assign out_stage_s = logic_stage_t'(data_vec_s[PIPE_STAGES-1]);
  assign out_valid   = valid_vec_s[PIPE_STAGES-1];
  assign out         = out_stage_s.data;
  assign zero        = out_stage_s.zero;
  assign parity      = out_stage_s.parity;
  assign op_err      = out_stage_s.op_err;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: a 16-bit two-stage unit and a 5-bit
// single-stage unit share clock and reset.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vdd = 1'b1;
  logic        vss = 1'b0;

  logic        in_valid, in_ready, out_valid, out_ready, zero, parity, op_err;
  logic [2:0]  op;
  logic [15:0] a, b, out;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, zero2, parity2, op_err2;
  logic [2:0]  op2;
  logic [4:0]  a2, b2, out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(16), .PIPE_STAGES(2)) dut (
    .clkpos(clk), .rst_n(rst_n), .vdd(vdd), .vss(vss),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .parity(parity), .op_err(op_err)
  );

  logic_unit_pipe #(.WIDTH(5), .PIPE_STAGES(1)) dut5 (
    .clkpos(clk), .rst_n(rst_n), .vdd(vdd), .vss(vss),
    .in_valid(in_valid2), .in_ready(in_ready2), .op(op2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out(out2),
    .zero(zero2), .parity(parity2), .op_err(op_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the 16-bit unit's full output bundle
  task automatic chk_out(input string tag, input logic v, input logic [15:0] d,
                         input logic z, input logic p, input logic e);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".out"},       {16'd0, out},       {16'd0, d});
    chk({tag, ".zero"},      {31'd0, zero},      {31'd0, z});
    chk({tag, ".parity"},    {31'd0, parity},    {31'd0, p});
    chk({tag, ".op_err"},    {31'd0, op_err},    {31'd0, e});
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    in_valid = v; op = o; a = x; b = y;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'd0, 16'h0000, 16'h0000);
    in_valid2 = 1'b0; op2 = 3'd0; a2 = 5'd0; b2 = 5'd0; out_ready2 = 1'b1;
    #1;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk_out("rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("rst.out_valid5", {31'd0, out_valid2}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single AND, latency two edges
    drive(1'b1, 3'd0, 16'hF0F0, 16'hFF00);
    @(negedge clk);
    chk("and.lat1", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 3'd0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk_out("and", 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("and.drain", {31'd0, out_valid}, 32'd0);
    chk("and.hold", {16'd0, out}, {16'd0, 16'hF000});

    // Back-to-back NOR then XOR
    drive(1'b1, 3'd3, 16'hFFFF, 16'h0000);
    chk("b2b.rdy0", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(1'b1, 3'd2, 16'hAAAA, 16'h5555);
    chk("b2b.rdy1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk_out("nor", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("b2b.rdy2", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 3'd0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk_out("xor", 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.drain", {31'd0, out_valid}, 32'd0);

    // Stall: fill with out_ready low, then release
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 16'h0001, 16'h0002);
    chk("stall.rdy0", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("stall.rdy1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 3'd1, 16'h0010, 16'h0020);
    @(negedge clk);
    chk("stall.full", {31'd0, in_ready}, 32'd0);
    chk_out("stall.a", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 16'hFFFF, 16'h00FF);
    @(negedge clk);
    chk("stall.full2", {31'd0, in_ready}, 32'd0);
    chk_out("stall.hold", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("stall.rdy_rise", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk_out("stall.b", 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk_out("stall.c", 1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall.drain", {31'd0, out_valid}, 32'd0);

    // Reserved op, then PASSA with odd parity
    drive(1'b1, 3'd7, 16'h1234, 16'h5678);
    @(negedge clk);
    drive(1'b1, 3'd6, 16'h0007, 16'hFFFF);
    @(negedge clk);
    chk_out("rsvd", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk_out("passa", 1'b1, 16'h0007, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Asynchronous reset with two results in flight
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    drive(1'b1, 3'd2, 16'h0F0F, 16'h0000);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0000, 16'h0000);
    chk_out("flight", 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst.no_stale", {31'd0, out_valid}, 32'd0);
    end

    // 5-bit single-stage ANDN
    in_valid2 = 1'b1; op2 = 3'd5; a2 = 5'b10111; b2 = 5'b00110;
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("w5.out_valid", {31'd0, out_valid2}, 32'd1);
    chk("w5.out", {27'd0, out2}, {27'd0, 5'b10001});
    chk("w5.parity", {31'd0, parity2}, 32'd0);
    chk("w5.zero", {31'd0, zero2}, 32'd0);
    chk("w5.op_err", {31'd0, op_err2}, 32'd0);
    @(negedge clk);
    chk("w5.drain", {31'd0, out_valid2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit for the MIPS25 ALU datapath. It generalises the fixed 16-bit AND slice to WIDTH bits and several selectable logic operations. It registers results through PIPE_STAGES stages, modelling the adiabatic phase latency, and uses a valid/ready handshake with bubble collapse and zero/parity/error flags. It sits between operand fetch and the ALU result mux.

## Interface
Parameters:
- WIDTH, 16: operand and result width in bits (≥ 1).
- PIPE_STAGES, 2: register stages from input acceptance to output (≥ 1).

Ports:
- clkpos  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- vdd, vss  input  1  supply pins, kept for netlist compatibility; no logic function.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  unit accepts this cycle.
- op  input  3  operation code (logic_op_t).
- a, b  input  WIDTH  operands.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts this cycle.
- out  output  WIDTH  result.
- zero  output  1  out == 0.
- parity  output  1  XOR-reduction of out.
- op_err  output  1  the result came from an undefined op code.

## Operation
- op codes:
  - 0 AND: a&b.
  - 1 OR: a|b.
  - 2 XOR: a^b.
  - 3 NOR: ~(a|b).
  - 4 NAND: ~(a&b).
  - 5 ANDN: a&~b.
  - 6 PASSA: a.
  - 7 is undefined: result all-zero, op_err=1.
- Result, zero, parity and op_err are computed combinationally at acceptance and captured into stage 0. Later stages copy data and flags unchanged.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Each stage holds a valid bit.
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage advances when out_ready is high or it is empty.
- in_ready = !valid[0] || stage-0 advancing. It is combinational from out_ready through the chain; bubbles collapse, so a partially filled pipe accepts while out_ready=0.
- A stalled stage holds data and flags stable. out and flags must not change while out_valid && !out_ready.
- Stage registers load only on advance; a non-advancing stage retains its value.
- Ordering is strictly in-order; no drops, no duplicates.

## Timing
- Reset (asynchronous, rst_n low):
  - All valid bits clear; out, zero, parity and op_err go to 0.
  - in_ready goes to 1 immediately and remains 1 during reset.
- Reset mid-operation discards all in-flight results with no output transfer. The first acceptance after rst_n rises is on the first clkpos edge with in_valid high.
- Latency: input accepted at edge N gives out_valid high after edge N+PIPE_STAGES-1, so the result is observable in the cycle following that edge. With PIPE_STAGES=1, output appears the cycle after acceptance.
- Throughput: one result per cycle with out_ready held high.
- Capacity: PIPE_STAGES entries. With the pipe full and out_ready=0, in_ready=0.
- Full pipe with out_ready rising: in_ready rises in the same cycle, and the simultaneous accept and emit both complete on that edge.
- Empty pipe with in_valid=0: out_valid=0 and out holds its last value (or 0 after reset). zero reflects the held out.

## Structure
- Shared package alu_logic_pkg holds:
  - typedef enum logic [2:0] logic_op_t (OP_AND..OP_PASSA, OP_RSVD=7);
  - constant LOGIC_OP_W=3;
  - a packed struct logic_stage_t {data, zero, parity, op_err} parameterised by WIDTH through a function-free typedef in the module.
- One sub-module, logic_pipe_stage: a single valid/data register with advance logic. It is instantiated PIPE_STAGES times via generate.
- The combinational op decode stays in the top module.

## Test plan
- WIDTH=16, PIPE_STAGES=2, AND a=16'hF0F0 b=16'hFF00, out_ready=1 → out=16'hF000 two cycles later, zero=0, parity=0, op_err=0.
- Back-to-back NOR a=16'hFFFF b=16'h0000, then XOR a=16'hAAAA b=16'h5555, out_ready=1 → out=16'h0000 (zero=1) then 16'hFFFF (parity=0) on consecutive cycles, in_ready constant 1.
- out_ready=0, three inputs offered → two accepted, in_ready=0 on the third, out/flags stable. out_ready=1 → both results emerge in order, third accepted on the same edge.
- op=7 with a=16'h1234 → out=16'h0000, op_err=1, zero=1.
- rst_n pulsed low asynchronously with two results in flight → out_valid=0 and out=0 immediately, in_ready=1, no stale result emitted after release.
- WIDTH=5, PIPE_STAGES=1, ANDN a=5'b10111 b=5'b00110 → out=5'b10001 one cycle after acceptance, parity=0.
